// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing: position counters, syncs, active-video flag and line/frame strobes
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       line_end,
    output logic       frame_end
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       video_on_q, video_on_d;
    logic       h_last;
    logic       v_last;

    assign h_last = (hc_q == H_LAST);
    assign v_last = (vc_q == V_LAST);

    // Counter next state: advance one pixel per ce, vertical steps on horizontal wrap
    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (ce) begin
            if (h_last) begin
                hc_d = 10'd0;
                vc_d = v_last ? 10'd0 : vc_q + 10'd1;
            end else begin
                hc_d = hc_q + 10'd1;
            end
        end
    end

    // Region decode from the current position; registered below, so outputs lag counters by one clk
    always_comb begin
        hsync_d    = ((hc_q >= HS_START) && (hc_q < HS_END)) ? SYNC_POL : ~SYNC_POL;
        vsync_d    = ((vc_q >= VS_START) && (vc_q < VS_END)) ? SYNC_POL : ~SYNC_POL;
        video_on_d = (hc_q < H_VIS) && (vc_q < V_VIS);
    end

    // State registers; reset dominates ce and parks syncs at their inactive level
    always_ff @(posedge clk) begin
        if (rst) begin
            hc_q       <= 10'd0;
            vc_q       <= 10'd0;
            hsync_q    <= ~SYNC_POL;
            vsync_q    <= ~SYNC_POL;
            video_on_q <= 1'b0;
        end else begin
            hc_q       <= hc_d;
            vc_q       <= vc_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            video_on_q <= video_on_d;
        end
    end

    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign video_on  = video_on_q;
    assign pixel_x   = hc_q;
    assign pixel_y   = vc_q;
    assign line_end  = ce & ~rst & h_last;
    assign frame_end = line_end & v_last;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic ce  = 1'b0;
    logic rst = 1'b1;
    int   sel = 0;

    logic [2:0] ce_w, rst_w;
    logic [2:0] hs_w, vs_w, von_w, le_w, fe_w;
    logic [9:0] px_w [3];
    logic [9:0] py_w [3];

    logic       o_hs, o_vs, o_von, o_le, o_fe;
    logic [9:0] o_px, o_py;
    logic       le_pre, fe_pre;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Only the selected instance sees ce and rst; the others are held in reset
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            ce_w[k]  = (sel == k) ? ce : 1'b0;
            rst_w[k] = (sel == k) ? rst : 1'b1;
        end
        o_hs  = hs_w[sel];
        o_vs  = vs_w[sel];
        o_von = von_w[sel];
        o_le  = le_w[sel];
        o_fe  = fe_w[sel];
        o_px  = px_w[sel];
        o_py  = py_w[sel];
    end

    vga_timing_gen u_dflt (
        .clk(clk), .rst(rst_w[0]), .ce(ce_w[0]),
        .hsync(hs_w[0]), .vsync(vs_w[0]), .video_on(von_w[0]),
        .pixel_x(px_w[0]), .pixel_y(py_w[0]),
        .line_end(le_w[0]), .frame_end(fe_w[0])
    );

    // Small raster: H total 24 (sync 18..21), V total 18 (sync 14..15)
    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) u_small (
        .clk(clk), .rst(rst_w[1]), .ce(ce_w[1]),
        .hsync(hs_w[1]), .vsync(vs_w[1]), .video_on(von_w[1]),
        .pixel_x(px_w[1]), .pixel_y(py_w[1]),
        .line_end(le_w[1]), .frame_end(fe_w[1])
    );

    vga_timing_gen #(.SYNC_POL(1'b1)) u_pos (
        .clk(clk), .rst(rst_w[2]), .ce(ce_w[2]),
        .hsync(hs_w[2]), .vsync(vs_w[2]), .video_on(von_w[2]),
        .pixel_x(px_w[2]), .pixel_y(py_w[2]),
        .line_end(le_w[2]), .frame_end(fe_w[2])
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clk: drive ce at negedge, capture strobes before the edge, settle after it
    task automatic clk1(input logic c);
        @(negedge clk);
        ce = c;
        #1;
        le_pre = o_le;
        fe_pre = o_fe;
        @(posedge clk);
        #1;
    endtask

    task automatic pixel();
        clk1(1'b1);
        clk1(1'b0);
        clk1(1'b0);
        clk1(1'b0);
    endtask

    initial begin
        int strobes, prev_hc, le_hc, lecnt, fecnt, lowcnt, hicnt;
        int t656, t752, t640, tfall, trise, tvf, fe_idx, le_at_fe, le1, le2, hs_first_hc;
        int s_hc, s_vc, s_hs, s_vs, s_von, guard;

        // ---------------- default raster, ce 1-in-4 ----------------
        sel = 0;
        rst = 1'b1;
        strobes = 0;
        for (int i = 0; i < 5; i++) begin
            clk1(i % 4 == 0);
            strobes += int'(le_pre) + int'(fe_pre);
        end
        check("rst_hc", o_px, 0);
        check("rst_vc", o_py, 0);
        check("rst_hs", o_hs, 1);
        check("rst_vs", o_vs, 1);
        check("rst_von", o_von, 0);
        check("rst_strobes", strobes, 0);
        rst = 1'b0;
        clk1(1'b0);
        check("rel_von", o_von, 1);
        check("rel_hs", o_hs, 1);

        t656 = -1; t752 = -1; t640 = -1; tfall = -1; trise = -1; tvf = -1;
        lowcnt = 0; lecnt = 0; fecnt = 0; le_hc = -1;
        for (int i = 0; i < 3200; i++) begin
            prev_hc = o_px;
            clk1(i % 4 == 0);
            if (le_pre) begin lecnt++; le_hc = prev_hc; end
            if (fe_pre) fecnt++;
            if (o_px == 656 && t656 < 0) t656 = i;
            if (o_px == 752 && t752 < 0) t752 = i;
            if (o_px == 640 && t640 < 0) t640 = i;
            if (!o_hs) lowcnt++;
            if (!o_hs && tfall < 0) tfall = i;
            if (o_hs && tfall >= 0 && trise < 0) trise = i;
            if (!o_von && tvf < 0) tvf = i;
        end
        check("hs_fall_lag", tfall - t656, 1);
        check("hs_rise_lag", trise - t752, 1);
        check("hs_low_clks", lowcnt, 384);
        check("von_fall_lag", tvf - t640, 1);
        check("line_end_cnt", lecnt, 1);
        check("line_end_hc", le_hc, 799);
        check("frame_end_cnt", fecnt, 0);
        check("line_wrap_hc", o_px, 0);
        check("line_wrap_vc", o_py, 1);
        check("line_vs", o_vs, 1);

        // ce stall at hc=700
        guard = 0;
        while (o_px != 700 && guard < 2000) begin pixel(); guard++; end
        check("stall_reach", o_px, 700);
        s_hc = o_px; s_vc = o_py; s_hs = o_hs; s_vs = o_vs; s_von = o_von;
        check("stall_hs_level", s_hs, 0);
        strobes = 0;
        for (int i = 0; i < 50; i++) begin
            clk1(1'b0);
            strobes += int'(le_pre) + int'(fe_pre);
        end
        check("stall_strobes", strobes, 0);
        check("stall_hc", o_px, s_hc);
        check("stall_vc", o_py, s_vc);
        check("stall_hs", o_hs, s_hs);
        check("stall_vs", o_vs, s_vs);
        check("stall_von", o_von, s_von);
        clk1(1'b1);
        check("stall_resume", o_px, 701);

        // ---------------- small raster: full frame and mid-frame reset ----------------
        sel = 1;
        rst = 1'b1;
        clk1(1'b0);
        rst = 1'b0;
        clk1(1'b0);
        lowcnt = 0; lecnt = 0; fecnt = 0; fe_idx = -1; le_at_fe = 0;
        for (int i = 0; i < 1728; i++) begin
            clk1(i % 4 == 0);
            if (le_pre) lecnt++;
            if (fe_pre) begin fecnt++; fe_idx = i; le_at_fe = int'(le_pre); end
            if (!o_vs) lowcnt++;
        end
        check("sm_vs_low_clks", lowcnt, 192);
        check("sm_frame_end_cnt", fecnt, 1);
        check("sm_frame_end_idx", fe_idx, 1724);
        check("sm_both_strobes", le_at_fe, 1);
        check("sm_line_end_cnt", lecnt, 18);
        check("sm_wrap_hc", o_px, 0);
        check("sm_wrap_vc", o_py, 0);

        guard = 0;
        while (!(o_px == 19 && o_py == 15) && guard < 1000) begin pixel(); guard++; end
        check("mr_reach_hc", o_px, 19);
        check("mr_reach_vc", o_py, 15);
        check("mr_hs_active", o_hs, 0);
        check("mr_vs_active", o_vs, 0);
        rst = 1'b1;
        clk1(1'b1);
        rst = 1'b0;
        check("mr_strobe", le_pre, 0);
        check("mr_hc", o_px, 0);
        check("mr_vc", o_py, 0);
        check("mr_hs", o_hs, 1);
        check("mr_vs", o_vs, 1);
        clk1(1'b0);
        check("mr_von", o_von, 1);

        // ---------------- default raster, free-running ce, active-high syncs ----------------
        sel = 2;
        rst = 1'b1;
        clk1(1'b1);
        check("pos_rst_hs", o_hs, 0);
        check("pos_rst_vs", o_vs, 0);
        rst = 1'b0;
        le1 = -1; le2 = -1; hicnt = 0; hs_first_hc = -1;
        for (int i = 0; i < 1700; i++) begin
            clk1(1'b1);
            if (le_pre) begin
                if (le1 < 0) le1 = i;
                else if (le2 < 0) le2 = i;
            end
            if (o_hs && hs_first_hc < 0) hs_first_hc = o_px;
            if (le1 >= 0 && le2 < 0 && i > le1 && o_hs) hicnt++;
        end
        check("pos_line_period", le2 - le1, 800);
        check("pos_hs_high_clks", hicnt, 96);
        check("pos_hs_first_hc", hs_first_hc, 657);
        check("pos_vs_idle", o_vs, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Consumes the 25 MHz pixel clock-enable produced by the prescaler in the 100 MHz `clk` domain. Generates the VGA raster: horizontal and vertical position counters, sync pulses, the active-video flag, and end-of-line and end-of-frame strobes. The 7-segment pixel renderer reads `pixel_x`, `pixel_y` and `video_on`. `hsync` and `vsync` drive the connector pins.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `SYNC_POL`, 0, asserted level of `hsync` and `vsync` (0 = active-low)

Derived values:
- H_TOTAL = sum of H params = 800
- V_TOTAL = sum of V params = 525

Ports:
- `clk` in 1: system clock, 100 MHz
- `rst` in 1: reset, synchronous, active-high
- `ce` in 1: pixel enable (prescaler `ceo`), one clk every 4
- `hsync` out 1: horizontal sync, registered
- `vsync` out 1: vertical sync, registered
- `video_on` out 1: high while the current position is in the visible area, registered
- `pixel_x` out 10: horizontal counter hc, 0..H_TOTAL-1
- `pixel_y` out 10: vertical counter vc, 0..V_TOTAL-1
- `line_end` out 1: single-clk strobe, combinational, ce & (hc == H_TOTAL-1)
- `frame_end` out 1: single-clk strobe, combinational, line_end & (vc == V_TOTAL-1)

## Operation
Counters:
- hc and vc are 10-bit registers. `pixel_x` = hc and `pixel_y` = vc directly.
- They advance only on clk edges where `ce`=1.
- hc: if hc == H_TOTAL-1, hc <= 0; else hc <= hc+1.
- vc: changes only when hc wraps. If vc == V_TOTAL-1, vc <= 0; else vc <= vc+1.
- hc and vc never reach H_TOTAL or V_TOTAL. No arithmetic overflow is possible at 10 bits.

Horizontal regions, in order: active [0, H_ACTIVE-1], front porch, sync, back porch. Vertical regions follow the same order.

Registered decodes, updated every clk edge from the current hc and vc, not gated by `ce`:
- `hsync` = SYNC_POL when H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC; otherwise the inverse. Defaults: hc 656..751.
- `vsync` = SYNC_POL when V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC; otherwise the inverse. Defaults: vc 490..491.
- `video_on` = (hc < H_ACTIVE) & (vc < V_ACTIVE).

Boundary and corner cases:
- `ce` held low: counters and all registered outputs freeze. Strobes stay 0.
- `ce` high every clk (free-running): the block works identically, one pixel per clk.
- Last pixel of the frame (hc=799, vc=524, ce=1): both strobes are high in the same clk. Next state is (0,0).
- `rst` with `ce` asserted in the same clk: reset wins.

Reset, including mid-frame:
- hc=0, vc=0.
- `hsync` and `vsync` = ~SYNC_POL (inactive).
- `video_on`=0.
- Strobes are 0 while `rst` is high (gated by ~rst).
- Reset takes effect at the first clk edge with `rst`=1 and is held for as long as `rst` stays high.

## Timing
- Counter latency: hc and vc update on the clk edge where `ce`=1.
- Decode latency: `hsync`, `vsync` and `video_on` follow the counters by exactly one clk. At the 4:1 ce ratio they are stable for 3 of the 4 clks of each pixel. The renderer must sample `video_on` with the same one-clk lag.
- First edge after reset release: `video_on` goes to 1 (position (0,0) is visible). `hsync` and `vsync` stay inactive.
- Line period = H_TOTAL ce pulses = 3200 clk at the 4:1 ratio.
- Frame period = H_TOTAL*V_TOTAL ce pulses = 420000 ce pulses = 1,680,000 clk.
- Strobe timing: `line_end` and `frame_end` are high in the same clk as the ce that wraps the counter. They are never wider than one clk.

## Test plan
- **Reset:** hold `rst`=1 for 5 clk with `ce` toggling 1-in-4. Required: hc=0, vc=0, `hsync`=1, `vsync`=1, `video_on`=0, strobes 0. One clk after release: `video_on`=1.
- **Horizontal:** `ce` 1-in-4, one full line.
  - `hsync` goes low 1 clk after hc becomes 656 and returns high 1 clk after hc becomes 752. Low for 96 pixels = 384 clk.
  - `video_on` falls 1 clk after hc=640.
  - `line_end` pulses once, on the ce where hc=799; hc then becomes 0 and vc increments.
- **Vertical and frame:** run a full frame.
  - `vsync` is low for vc 490..491, i.e. exactly 2*3200 clk.
  - `frame_end` fires once, after 1,680,000 clk.
  - Position returns to (0,0).
- **ce stall:** drop `ce` for 50 clk at hc=700, vc=100. Required: all outputs unchanged and no strobes. Counting resumes at 701 on the next `ce`.
- **Mid-frame reset:** assert `rst` for 1 clk at hc=660, vc=491, while both syncs are asserted. Required: on the next clk hc=0, vc=0 and both syncs inactive; on the following clk `video_on`=1.
- **Free-running ce plus parameter override:** `ce`=1 constantly, SYNC_POL=1. Required: line period is 800 clk and the syncs are active-high with the same windows.
